elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
// Walks a destination queue one entry at a time, moving the car floor by
// floor on a tick time base and holding the door open at every stop.
//
// Ports:
//   clk            - single clock, all state changes on the rising edge
//   rst_n          - asynchronous active-low reset
//   start          - level, begins/restarts a run from IDLE or DONE
//   tick           - one-cycle time-base pulse, used in MOVE and DOOR only
//   address[7:0]   - registered index into the destination queue
//   destino[23:0]  - queue entry at address, only bits [1:0] are a floor code
//   piso_actual    - current floor code (00=-1, 01=1, 10=2, 11=3)
//   subiendo       - high while moving up
//   bajando        - high while moving down
//   puerta_abierta - high while the door is open
//   done           - high while the queue is exhausted

module elevator_scheduler #(
   parameter int QUEUE_LEN    = 10,
   parameter int TRAVEL_TICKS = 2,
   parameter int DOOR_TICKS   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        tick,
   output logic [7:0]  address,
   input  logic [23:0] destino,
   output logic [1:0]  piso_actual,
   output logic        subiendo,
   output logic        bajando,
   output logic        puerta_abierta,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MOVE,
      DOOR,
      DONE
   } state_t;

   localparam int STEP_W = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS + 1) : 1;
   localparam int DOOR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS + 1) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TRAVEL_TICKS - 1);
   localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_TICKS - 1);
   localparam logic [7:0]        ADDR_LAST = 8'(QUEUE_LEN - 1);

   state_t            state, state_nxt;
   logic [7:0]        address_nxt;
   logic [1:0]        piso_nxt;
   logic              subiendo_nxt, bajando_nxt, puerta_nxt, done_nxt;
   logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
   logic [DOOR_W-1:0] door_cnt, door_cnt_nxt;
   logic [1:0]        target, target_nxt;
   logic [1:0]        dest_floor;
   logic [1:0]        step_floor;
   logic              can_step;

   // Only the two floor bits of a queue entry matter; the rest is folded
   // into a deliberately unused signal.
   logic unused_destino_hi;
   assign unused_destino_hi = ^destino[23:2];

   assign dest_floor = destino[1:0];

   // Floor the car reaches on its next step, and whether that step stays
   // inside 00..11 so the floor code can never wrap.
   always_comb begin
      step_floor = subiendo ? (piso_actual + 2'd1) : (piso_actual - 2'd1);
      can_step   = (subiendo && (piso_actual != 2'b11)) ||
                   (bajando  && (piso_actual != 2'b00));
   end

   // Every register lives here; the async reset puts the car at floor 1,
   // idle with the door closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         address        <= 8'd0;
         piso_actual    <= 2'b01;
         subiendo       <= 1'b0;
         bajando        <= 1'b0;
         puerta_abierta <= 1'b0;
         done           <= 1'b0;
         step_cnt       <= '0;
         door_cnt       <= '0;
         target         <= 2'b00;
      end else begin
         state          <= state_nxt;
         address        <= address_nxt;
         piso_actual    <= piso_nxt;
         subiendo       <= subiendo_nxt;
         bajando        <= bajando_nxt;
         puerta_abierta <= puerta_nxt;
         done           <= done_nxt;
         step_cnt       <= step_cnt_nxt;
         door_cnt       <= door_cnt_nxt;
         target         <= target_nxt;
      end
   end

   // Next-state and next-output logic. Outputs are computed here as the
   // values they will hold after the edge, so all of them come out of flops.
   // Ticks seen in FETCH are dropped, and the tick that lands the car on its
   // target is consumed by the move, so the door count always starts clean.
   always_comb begin
      state_nxt    = state;
      address_nxt  = address;
      piso_nxt     = piso_actual;
      subiendo_nxt = subiendo;
      bajando_nxt  = bajando;
      puerta_nxt   = puerta_abierta;
      done_nxt     = done;
      step_cnt_nxt = step_cnt;
      door_cnt_nxt = door_cnt;
      target_nxt   = target;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = FETCH;
               address_nxt = 8'd0;
            end
         end

         FETCH: begin
            target_nxt = dest_floor;
            if (dest_floor == piso_actual) begin
               state_nxt    = DOOR;
               puerta_nxt   = 1'b1;
               door_cnt_nxt = '0;
            end else begin
               state_nxt    = MOVE;
               subiendo_nxt = (dest_floor > piso_actual);
               bajando_nxt  = (dest_floor < piso_actual);
               step_cnt_nxt = '0;
            end
         end

         MOVE: begin
            if (tick) begin
               if (step_cnt == STEP_LAST) begin
                  step_cnt_nxt = '0;
                  if (can_step) begin
                     piso_nxt = step_floor;
                     if (step_floor == target) begin
                        state_nxt    = DOOR;
                        subiendo_nxt = 1'b0;
                        bajando_nxt  = 1'b0;
                        puerta_nxt   = 1'b1;
                        door_cnt_nxt = '0;
                     end
                  end
               end else begin
                  step_cnt_nxt = step_cnt + 1'b1;
               end
            end
         end

         DOOR: begin
            if (tick) begin
               if (door_cnt == DOOR_LAST) begin
                  puerta_nxt   = 1'b0;
                  door_cnt_nxt = '0;
                  if (address == ADDR_LAST) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt   = FETCH;
                     address_nxt = address + 8'd1;
                  end
               end else begin
                  door_cnt_nxt = door_cnt + 1'b1;
               end
            end
         end

         DONE: begin
            if (start) begin
               state_nxt   = FETCH;
               address_nxt = 8'd0;
               done_nxt    = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler
// Scoreboarded bench for elevator_scheduler. Each run pushes the expected
// sequence of stops (address, floor, direction, travel ticks) plus a final
// "queue exhausted" record; a monitor pops a record whenever the door opens
// or done rises and compares it with what the car actually did.
//
// Ports: none (top-level bench).

module tb_elevator_scheduler;

   localparam int QLEN = 10;
   localparam int TT   = 2;
   localparam int DT   = 3;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        tick;
   logic [7:0]  address;
   logic [23:0] destino;
   logic [1:0]  piso_actual;
   logic        subiendo;
   logic        bajando;
   logic        puerta_abierta;
   logic        done;

   typedef struct {
      bit is_done;
      int addr;
      int floor;
      int dir;
      int ticks;
   } sb_item_t;

   sb_item_t    sb[$];
   logic [23:0] qmem [QLEN];
   int          checks      = 0;
   int          failures    = 0;
   int          model_floor = 1;
   int          tick_mode   = 0;
   int          fixed_list [QLEN] = '{3, 0, 2, 1, 3, 1, 0, 2, 3, 1};

   elevator_scheduler #(
      .QUEUE_LEN   (QLEN),
      .TRAVEL_TICKS(TT),
      .DOOR_TICKS  (DT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .tick          (tick),
      .address       (address),
      .destino       (destino),
      .piso_actual   (piso_actual),
      .subiendo      (subiendo),
      .bajando       (bajando),
      .puerta_abierta(puerta_abierta),
      .done          (done)
   );

   assign destino = (int'(address) < QLEN) ? qmem[address] : 24'h0;

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick source: off, random (about one cycle in three) or every 4 cycles.
   // Driven 2 ns after the rising edge so it is stable when sampled.
   initial begin
      int phase;
      phase = 0;
      tick  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         phase = (phase + 1) % 4;
         case (tick_mode)
            1:       tick = ($urandom_range(0, 2) == 0);
            2:       tick = (phase == 0);
            default: tick = 1'b0;
         endcase
      end
   end

   // Global time limit so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s);
      @(posedge clk);
      #2;
      start = s;
   endtask

   // Reference model: the car visits each queue entry in order; a leg costs
   // TRAVEL ticks per floor of distance and its direction is the sign of the
   // floor difference. A final record stands for the exhausted queue.
   task automatic modelRun();
      int       cur;
      int       d;
      sb_item_t it;
      cur = model_floor;
      for (int i = 0; i < QLEN; i++) begin
         d          = int'(qmem[i][1:0]);
         it.is_done = 1'b0;
         it.addr    = i;
         it.floor   = d;
         it.dir     = (d > cur) ? 1 : ((d < cur) ? 2 : 0);
         it.ticks   = ((d > cur) ? (d - cur) : (cur - d)) * TT;
         sb.push_back(it);
         cur = d;
      end
      it.is_done = 1'b1;
      it.addr    = QLEN - 1;
      it.floor   = cur;
      it.dir     = 0;
      it.ticks   = 0;
      sb.push_back(it);
      model_floor = cur;
   endtask

   task automatic loadRandomQueue();
      for (int i = 0; i < QLEN; i++) qmem[i] = 24'($urandom);
      qmem[3][1:0] = qmem[2][1:0];
   endtask

   task automatic startRun();
      modelRun();
      applyStimulus(1'b1);
      applyStimulus(1'b0);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("run_done", int'(done), 1);
   endtask

   task automatic waitMoving();
      int n;
      n = 0;
      while (!(subiendo || bajando) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reach_move", int'(subiendo | bajando), 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_address"}, int'(address), 0);
      checkOutput({tag, "_piso"}, int'(piso_actual), 1);
      checkOutput({tag, "_subiendo"}, int'(subiendo), 0);
      checkOutput({tag, "_bajando"}, int'(bajando), 0);
      checkOutput({tag, "_puerta"}, int'(puerta_abierta), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
   endtask

   // Monitor: sampled on the falling edge, well away from the active edge.
   // It tracks ticks consumed while moving and while the door is open, the
   // direction flags seen during a leg, and pops the scoreboard on each
   // door opening and each rise of done.
   initial begin
      logic     prev_door, prev_done;
      logic [1:0] prev_piso;
      int       move_ticks, door_ticks, obs_dir, dstep;
      bit       saw_up, saw_down;
      sb_item_t it;
      prev_door = 1'b0; prev_done = 1'b0; prev_piso = 2'b01;
      move_ticks = 0; door_ticks = 0; saw_up = 0; saw_down = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_door = 1'b0; prev_done = 1'b0; prev_piso = 2'b01;
            move_ticks = 0; door_ticks = 0; saw_up = 0; saw_down = 0;
         end else begin
            if (subiendo || bajando) begin
               checkOutput("dir_exclusive", int'(subiendo & bajando), 0);
               saw_up   = saw_up | subiendo;
               saw_down = saw_down | bajando;
            end
            if (piso_actual != prev_piso) begin
               dstep = int'(piso_actual) - int'(prev_piso);
               if (dstep < 0) dstep = -dstep;
               checkOutput("floor_step", dstep, 1);
            end
            if (puerta_abierta && !prev_door) begin
               if (sb.size() == 0) begin
                  checkOutput("sb_door_underflow", 0, 1);
               end else begin
                  it = sb.pop_front();
                  obs_dir = saw_up ? (saw_down ? 3 : 1) : (saw_down ? 2 : 0);
                  checkOutput("stop_kind", int'(it.is_done), 0);
                  checkOutput("stop_address", int'(address), it.addr);
                  checkOutput("stop_floor", int'(piso_actual), it.floor);
                  checkOutput("stop_dir", obs_dir, it.dir);
                  checkOutput("stop_travel_ticks", move_ticks, it.ticks);
               end
               move_ticks = 0; door_ticks = 0; saw_up = 0; saw_down = 0;
            end
            if (!puerta_abierta && prev_door) begin
               checkOutput("door_ticks", door_ticks, DT);
            end
            if (done && !prev_done) begin
               if (sb.size() == 0) begin
                  checkOutput("sb_done_underflow", 0, 1);
               end else begin
                  it = sb.pop_front();
                  checkOutput("done_kind", int'(it.is_done), 1);
                  checkOutput("done_address", int'(address), it.addr);
                  checkOutput("done_floor", int'(piso_actual), it.floor);
               end
            end
            if ((subiendo || bajando) && tick) move_ticks++;
            if (puerta_abierta && tick) door_ticks++;
            prev_door = puerta_abierta;
            prev_done = done;
            prev_piso = piso_actual;
         end
      end
   end

   // Directed sequence of runs; expected results flow through the scoreboard.
   initial begin
      int n;
      int s_floor;
      rst_n = 1'b1;
      start = 1'b0;
      for (int i = 0; i < QLEN; i++) qmem[i] = 24'h0;

      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("reset");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      tick_mode = 1;
      repeat (10) @(negedge clk);
      checkResetValues("idle_hold");

      $display("[TB] fixed ten-entry queue, tick every 4 cycles");
      for (int i = 0; i < QLEN; i++) qmem[i] = {22'($urandom), 2'(fixed_list[i])};
      tick_mode = 2;
      startRun();
      waitDone();

      $display("[TB] ticks while in DONE");
      tick_mode = 1;
      repeat (20) @(negedge clk);
      checkOutput("done_hold_done", int'(done), 1);
      checkOutput("done_hold_address", int'(address), QLEN - 1);
      checkOutput("done_hold_piso", int'(piso_actual), model_floor);
      checkOutput("done_hold_puerta", int'(puerta_abierta), 0);

      $display("[TB] restart from DONE with random queue");
      loadRandomQueue();
      startRun();
      waitDone();

      $display("[TB] tick stall during MOVE");
      loadRandomQueue();
      qmem[0][1:0] = 2'(model_floor) ^ 2'b10;
      s_floor   = model_floor;
      tick_mode = 0;
      startRun();
      waitMoving();
      repeat (100) @(negedge clk);
      checkOutput("stall_piso", int'(piso_actual), s_floor);
      checkOutput("stall_moving", int'(subiendo | bajando), 1);
      checkOutput("stall_puerta", int'(puerta_abierta), 0);
      tick_mode = 1;
      waitDone();

      $display("[TB] reset between floors");
      loadRandomQueue();
      qmem[0][1:0] = 2'(model_floor) ^ 2'b10;
      startRun();
      n = 0;
      while (!((subiendo || bajando) && tick) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reach_mid_move", int'((subiendo | bajando) & tick), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("async_reset");
      sb.delete();
      model_floor = 1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkResetValues("post_reset_idle");

      $display("[TB] random runs");
      for (int r = 0; r < 3; r++) begin
         loadRandomQueue();
         startRun();
         waitDone();
      end

      repeat (5) @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
